// File: rtl/tbl_loader_pkg.sv
// Shared constants and state type for the math seed table write-side sequencer.
package tbl_loader_pkg;

  localparam int TBL_DEPTH   = 320;
  localparam int TBL_AW      = 9;
  localparam int TBL_DW      = 68;
  localparam int TBL_IDX_LSB = 45;
  localparam int TBL_IDX_MSB = 53;

  typedef enum logic [1:0] {
    TBL_LD_IDLE = 2'd0,
    TBL_LD_LOAD = 2'd1,
    TBL_LD_FIN  = 2'd2
  } tbl_ld_state_t;

endpackage

// File: rtl/tbl_loader.sv
// Streams entries into the math seed table at consecutive indices from a programmed base,
// reporting busy/done/range-error and an XOR checksum of what was written.
//
// Handshake: a beat transfers on any rising clk where in_valid && in_ready. in_ready is
// high exactly while in LOAD and does not depend on in_valid; in_data must be stable
// while in_valid is high.
module tbl_loader
  import tbl_loader_pkg::*;
#(
  parameter int DEPTH = TBL_DEPTH,
  parameter int AW    = TBL_AW,
  parameter int DW    = TBL_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] tbl_A,
  output logic [DW-1:0] tbl_B,
  output logic          tbl_is_write,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] xsum,
  output tbl_ld_state_t dbg_state
);

  tbl_ld_state_t state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [AW:0]   rem_q;
  logic          accept;
  logic          range_bad;
  logic          start_ok;
  logic          err_d;
  logic [DW-1:0] b_word;

  // One extra bit of headroom so base+count cannot overflow before the compare.
  assign range_bad = ({2'b00, base} + {1'b0, count}) > (AW + 2)'(DEPTH);
  assign in_ready  = (state_q == TBL_LD_LOAD);
  assign accept    = in_valid && (state_q == TBL_LD_LOAD);
  assign start_ok  = start && (state_q == TBL_LD_IDLE) && !range_bad;
  assign dbg_state = state_q;

  always_comb begin
    b_word = '0;
    b_word[TBL_IDX_MSB:TBL_IDX_LSB] = addr_q;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      TBL_LD_IDLE: begin
        if (start) begin
          if (range_bad)        err_d   = 1'b1;
          else if (count == '0) state_d = TBL_LD_FIN;
          else                  state_d = TBL_LD_LOAD;
        end
      end
      TBL_LD_LOAD: begin
        if (accept && rem_q == (AW + 1)'(1)) state_d = TBL_LD_FIN;
      end
      TBL_LD_FIN:  state_d = TBL_LD_IDLE;
      default:     state_d = TBL_LD_IDLE;
    endcase
  end

  // done and busy are registered from the next state so done lands in the FIN cycle,
  // alongside the write produced by the final accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= TBL_LD_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      tbl_A        <= '0;
      tbl_B        <= '0;
      tbl_is_write <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      xsum         <= '0;
    end else begin
      state_q      <= state_d;
      busy         <= (state_d != TBL_LD_IDLE);
      done         <= (state_d == TBL_LD_FIN);
      err          <= err_d;
      tbl_is_write <= accept;
      if (start_ok) begin
        addr_q <= base;
        rem_q  <= count;
        xsum   <= '0;
      end else if (accept) begin
        tbl_A  <= in_data;
        tbl_B  <= b_word;
        xsum   <= xsum ^ in_data;
        addr_q <= addr_q + AW'(1);
        rem_q  <= rem_q - (AW + 1)'(1);
      end
    end
  end

endmodule
